// File: rtl/value_change_pkg.sv
// Shared types for the value-change replay block: replay FSM states and
// record-width helper used to size the record FIFO.
package value_change_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vc_state_t;

    // Packed record layout is {time, value, last}.
    function automatic int unsigned rec_width(input int unsigned time_w, input int unsigned value_w);
        return time_w + value_w + 32'd1;
    endfunction

endpackage

// File: rtl/vc_record_fifo.sv
// Synchronous record FIFO with extra-bit pointers for full/empty detection.
// Writes while full and reads while empty are ignored.
module vc_record_fifo
    import value_change_pkg::*;
#(
    parameter int unsigned DW    = 49,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [DW-1:0] mem_r [DEPTH];
    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Full/empty decode and qualified push/pop strobes.
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_ok_s = push && !full_s;
        pop_ok_s  = pop && !empty_s;
    end

    // Pointer update; reset discards any buffered records.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign head  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/value_change_replay.sv
// Replays buffered (timestamp, value) records onto a registered bus, one
// record per cycle once the replay counter reaches each record's timestamp.
module value_change_replay
    import value_change_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TIME_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TIME_WIDTH-1:0] in_time,
    input  logic [WIDTH-1:0]      in_value,
    input  logic                  in_last,
    input  logic                  start,
    output logic [TIME_WIDTH-1:0] now,
    output logic [WIDTH-1:0]      out_value,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  late
);

    localparam int unsigned REC_W = rec_width(TIME_WIDTH, WIDTH);

    vc_state_t             state_r;
    logic [TIME_WIDTH-1:0] now_r;
    logic [WIDTH-1:0]      out_value_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  late_r;

    logic [REC_W-1:0]      wdata_s;
    logic [REC_W-1:0]      head_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [TIME_WIDTH-1:0] head_time_s;
    logic [WIDTH-1:0]      head_value_s;
    logic                  head_last_s;
    logic                  apply_s;

    assign wdata_s = {in_time, in_value, in_last};

    vc_record_fifo #(
        .DW    (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (wdata_s),
        .pop   (apply_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

    // Head record unpack and the apply comparator.
    always_comb begin
        head_time_s  = head_s[REC_W-1 -: TIME_WIDTH];
        head_value_s = head_s[WIDTH:1];
        head_last_s  = head_s[0];
        apply_s      = (state_r == RUN) && !fifo_empty_s && (head_time_s <= now_r);
    end

    // Replay FSM with the cycle counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            now_r       <= {TIME_WIDTH{1'b0}};
            out_value_r <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            late_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= RUN;
                        busy_r      <= 1'b1;
                        now_r       <= {TIME_WIDTH{1'b0}};
                        late_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                    end
                end
                RUN: begin
                    // Counter saturates rather than wrapping so late detection stays sound.
                    if (now_r != {TIME_WIDTH{1'b1}}) begin
                        now_r <= now_r + {{(TIME_WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (apply_s) begin
                        out_value_r <= head_value_s;
                        out_valid_r <= 1'b1;
                        if (head_time_s < now_r) begin
                            late_r <= 1'b1;
                        end
                        if (head_last_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = !fifo_full_s;
    assign now       = now_r;
    assign out_value = out_value_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign late      = late_r;

endmodule
